// File: rtl/frame_config_ctrl_pkg.sv
// Shared definitions for the configuration frame sequencer:
// FSM state encoding and header field positions.
package frame_config_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int unsigned HDR_FRAME_LSB = 0;
  localparam int unsigned HDR_COL_LSB   = 16;

endpackage

// File: rtl/frame_config_ctrl.sv
// Configuration frame sequencer: header word, then one data word per fabric row
// broadcast with its row code, then a single commit strobe to column/frame.
module frame_config_ctrl
  import frame_config_ctrl_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow  = 32,
  parameter int unsigned RowSelectWidth   = 5,
  parameter int unsigned NumberOfRows     = 16,
  parameter int unsigned ColSelectWidth   = 5,
  parameter int unsigned NumberOfCols     = 16,
  parameter int unsigned FrameSelectWidth = 5,
  parameter int unsigned MaxFramesPerCol  = 20
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [FrameBitsPerRow-1:0]  word_data,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic [FrameBitsPerRow-1:0]  FrameData,
  output logic [RowSelectWidth-1:0]   RowSelect,
  output logic [ColSelectWidth-1:0]   ColSelect,
  output logic [FrameSelectWidth-1:0] FrameSelect,
  output logic                        FrameStrobe,
  output logic                        busy,
  output logic                        err,
  input  logic                        err_clr
);

  // Row codes must fit the counter, and the header fields must fit the word.
  if (NumberOfRows == 0 || NumberOfRows >= (32'd1 << RowSelectWidth)) begin : g_bad_rows
    $error("frame_config_ctrl: NumberOfRows must be in 1..2**RowSelectWidth-1");
  end
  if (FrameBitsPerRow < HDR_COL_LSB + ColSelectWidth ||
      FrameBitsPerRow < HDR_FRAME_LSB + FrameSelectWidth) begin : g_bad_hdr
    $error("frame_config_ctrl: header fields exceed FrameBitsPerRow");
  end

  state_e                      state_q, state_d;
  logic [RowSelectWidth-1:0]   row_cnt_q, row_cnt_d;
  logic [ColSelectWidth-1:0]   col_q, col_d;
  logic [FrameSelectWidth-1:0] frame_q, frame_d;
  logic [FrameBitsPerRow-1:0]  frame_data_q, frame_data_d;
  logic [RowSelectWidth-1:0]   row_sel_q, row_sel_d;
  logic [ColSelectWidth-1:0]   col_sel_q, col_sel_d;
  logic [FrameSelectWidth-1:0] frame_sel_q, frame_sel_d;
  logic                        strobe_q, strobe_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;

  logic [ColSelectWidth-1:0]   hdr_col;
  logic [FrameSelectWidth-1:0] hdr_frame;
  logic                        hdr_bad;
  logic                        xfer;
  logic                        last_row;

  assign word_ready = (state_q != ST_STROBE);
  assign xfer       = word_valid && word_ready;
  assign hdr_col    = word_data[HDR_COL_LSB +: ColSelectWidth];
  assign hdr_frame  = word_data[HDR_FRAME_LSB +: FrameSelectWidth];
  assign hdr_bad    = (32'(hdr_col) >= NumberOfCols) || (32'(hdr_frame) >= MaxFramesPerCol);
  assign last_row   = (row_cnt_q == RowSelectWidth'(NumberOfRows));

  // Next-state and registered-output decode; row/strobe outputs default to idle.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_d        = col_q;
    frame_d      = frame_q;
    frame_data_d = frame_data_q;
    row_sel_d    = '0;
    col_sel_d    = '0;
    frame_sel_d  = '0;
    strobe_d     = 1'b0;
    err_d        = err_clr ? 1'b0 : err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          col_d     = hdr_col;
          frame_d   = hdr_frame;
          row_cnt_d = RowSelectWidth'(1);
          if (hdr_bad) begin
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          frame_data_d = word_data;
          row_sel_d    = row_cnt_q;
          row_cnt_d    = row_cnt_q + RowSelectWidth'(1);
          if (last_row) begin
            state_d     = ST_STROBE;
            strobe_d    = 1'b1;
            col_sel_d   = col_q;
            frame_sel_d = frame_q;
          end
        end
      end
      ST_STROBE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (xfer) begin
          row_cnt_d = row_cnt_q + RowSelectWidth'(1);
          if (last_row) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      row_cnt_q    <= RowSelectWidth'(1);
      col_q        <= '0;
      frame_q      <= '0;
      frame_data_q <= '0;
      row_sel_q    <= '0;
      col_sel_q    <= '0;
      frame_sel_q  <= '0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      frame_data_q <= frame_data_d;
      row_sel_q    <= row_sel_d;
      col_sel_q    <= col_sel_d;
      frame_sel_q  <= frame_sel_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign FrameData   = frame_data_q;
  assign RowSelect   = row_sel_q;
  assign ColSelect   = col_sel_q;
  assign FrameSelect = frame_sel_q;
  assign FrameStrobe = strobe_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Bench for frame_config_ctrl: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_frame_config_ctrl;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] FrameData;
  logic [4:0]  RowSelect;
  logic [4:0]  ColSelect;
  logic [4:0]  FrameSelect;
  logic        FrameStrobe;
  logic        busy;
  logic        err;
  logic        err_clr;

  frame_config_ctrl dut (
    .CLK(CLK), .resetn(resetn), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .FrameData(FrameData), .RowSelect(RowSelect),
    .ColSelect(ColSelect), .FrameSelect(FrameSelect), .FrameStrobe(FrameStrobe),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int strobes = 0;
  logic [4:0]  log_row[$];
  logic [31:0] log_data[$];

  // Reference model: frame-level bookkeeping of what each cycle must show.
  bit          collecting, discarding, strobe_cyc;
  int          rows_done, lat_col, lat_frm;
  logic [31:0] m_data;
  logic [4:0]  m_row, m_col, m_frm;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(posedge CLK or negedge resetn);
    if (!resetn) begin
      collecting = 0; discarding = 0; strobe_cyc = 0; rows_done = 0;
      m_data = '0; m_row = '0; m_col = '0; m_frm = '0; m_err = 1'b0;
    end else begin
      bit bad;
      bad = 0;
      m_row = '0; m_col = '0; m_frm = '0;
      if (strobe_cyc) begin
        strobe_cyc = 0;
      end else if (word_valid) begin
        if (!collecting && !discarding) begin
          lat_col = int'(word_data[20:16]);
          lat_frm = int'(word_data[4:0]);
          rows_done = 0;
          if (lat_col < 16 && lat_frm < 20) collecting = 1;
          else begin discarding = 1; bad = 1; end
        end else begin
          rows_done++;
          if (collecting) begin
            m_row = 5'(rows_done);
            m_data = word_data;
            if (rows_done == 16) begin
              collecting = 0; strobe_cyc = 1;
              m_col = 5'(lat_col); m_frm = 5'(lat_frm);
            end
          end else if (rows_done == 16) begin
            discarding = 0;
          end
        end
      end
      if (err_clr) m_err = 1'b0;
      if (bad) m_err = 1'b1;
    end
  end

  // Per-cycle comparison against the model, plus a log of row writes.
  initial forever begin
    @(negedge CLK);
    check("word_ready", 32'(word_ready), 32'(!strobe_cyc));
    check("FrameData", FrameData, m_data);
    check("RowSelect", 32'(RowSelect), 32'(m_row));
    check("ColSelect", 32'(ColSelect), 32'(m_col));
    check("FrameSelect", 32'(FrameSelect), 32'(m_frm));
    check("FrameStrobe", 32'(FrameStrobe), 32'(strobe_cyc));
    check("busy", 32'(busy), 32'(collecting || discarding || strobe_cyc));
    check("err", 32'(err), 32'(m_err));
    if (RowSelect != 0) begin
      log_row.push_back(RowSelect);
      log_data.push_back(FrameData);
    end
    if (FrameStrobe) strobes++;
  end

  function automatic logic [31:0] hdr(input int col, input int frm);
    logic [31:0] w;
    w = 32'h5A00_C300;
    w[23:21] = 3'b101;
    w[20:16] = 5'(col);
    w[4:0] = 5'(frm);
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one word and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [31:0] d, input logic clr);
    bit accepted;
    logic r;
    accepted = 0;
    word_valid = 1'b1;
    word_data = d;
    err_clr = clr;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(negedge CLK);
      r = word_ready;
      tick();
      if (r === 1'b1) begin
        accepted = 1;
        last_acc = cyc;
      end
    end
    err_clr = 1'b0;
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    word_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_log(input string name, input logic [31:0] base);
    check({name, "_rows"}, 32'(log_row.size()), 32'd16);
    for (int i = 0; i < log_row.size() && i < 16; i++) begin
      check({name, "_row"}, 32'(log_row[i]), 32'(i + 1));
      check({name, "_data"}, log_data[i], base + 32'(i + 1));
    end
    log_row.delete();
    log_data.delete();
  endtask

  initial begin
    int t0, s0;
    resetn = 1'b0; word_valid = 1'b0; word_data = '0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(word_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick();

    // Back-to-back frame, next header offered during the strobe cycle.
    log_row.delete(); log_data.delete();
    send(hdr(3, 7), 1'b0);
    t0 = last_acc;
    for (int i = 1; i <= 16; i++) send(32'hA000_0000 + 32'(i), 1'b0);
    check("strobe_col", 32'(ColSelect), 32'd3);
    check("strobe_frm", 32'(FrameSelect), 32'd7);
    check("strobe_pulse", 32'(FrameStrobe), 32'd1);
    check("strobe_ready", 32'(word_ready), 32'd0);
    send(hdr(3, 7), 1'b0);
    check("frame_period", 32'(last_acc - t0), 32'd18);
    check("strobes_a", 32'(strobes), 32'd1);
    check_log("frame_a", 32'hA000_0000);

    // Same frame with random valid gaps.
    for (int i = 1; i <= 16; i++) begin
      idle($urandom_range(0, 3));
      send(32'hA000_0000 + 32'(i), 1'b0);
    end
    idle(3);
    check("strobes_b", 32'(strobes), 32'd2);
    check_log("frame_b", 32'hA000_0000);

    // Reset after five rows of a frame.
    send(hdr(1, 2), 1'b0);
    for (int i = 1; i <= 5; i++) send(32'hB000_0000 + 32'(i), 1'b0);
    resetn = 1'b0;
    #1;
    check("mid_rst_row", 32'(RowSelect), 32'd0);
    check("mid_rst_data", FrameData, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(word_ready), 32'd1);
    check("mid_rst_strobe", 32'(FrameStrobe), 32'd0);
    word_valid = 1'b0;
    tick();
    resetn = 1'b1;
    idle(1);
    log_row.delete(); log_data.delete();
    s0 = strobes;
    send(hdr(15, 19), 1'b0);
    for (int i = 1; i <= 16; i++) send(32'hC000_0000 + 32'(i), 1'b0);
    idle(3);
    check("strobes_c", 32'(strobes - s0), 32'd1);
    check_log("frame_c", 32'hC000_0000);

    // Out-of-range column: drained without row writes or strobe.
    s0 = strobes;
    send(hdr(16, 0), 1'b0);
    word_valid = 1'b0;
    check("bad_col_err", 32'(err), 32'd1);
    check("bad_col_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 16; i++) send(32'hD000_0000 + 32'(i), 1'b0);
    idle(3);
    check("bad_col_busy_after", 32'(busy), 32'd0);
    check("bad_col_strobes", 32'(strobes - s0), 32'd0);
    check("bad_col_rows", 32'(log_row.size()), 32'd0);

    // err_clr alone clears; clear coinciding with a bad header loses.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_alone", 32'(err), 32'd0);
    send(hdr(0, 20), 1'b1);
    word_valid = 1'b0;
    check("set_wins", 32'(err), 32'd1);
    for (int i = 1; i <= 16; i++) send(32'hE000_0000 + 32'(i), 1'b0);
    idle(2);
    check("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_later", 32'(err), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
